// File: rtl/seq_products_mult.sv
// seq_products_mult: iterative unsigned multiplier that sums R AND-row partial
// products per cycle into a double-width accumulator, with valid/ready on both sides.
module seq_products_mult #(
  parameter int WIDTH      = 8,
  parameter int R          = 1,
  parameter bit EARLY_TERM = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int STEPS = WIDTH / R;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

  if (WIDTH < 2) begin : g_bad_width
    $error("seq_products_mult: WIDTH must be at least 2");
  end

  if (R < 1 || (WIDTH % R) != 0) begin : g_bad_rows
    $error("seq_products_mult: R must divide WIDTH exactly");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     ma_q, ma_d;
  logic [WIDTH-1:0]     mb_q, mb_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [2*WIDTH-1:0]   row_sum;
  logic [WIDTH-1:0]     mb_shifted;
  logic                 last_step;

  // Sum of this step's R partial-product rows, each aligned to its multiplier bit weight.
  always_comb begin
    row_sum = '0;
    for (int k = 0; k < R; k++) begin
      row_sum = row_sum +
                ({{WIDTH{1'b0}}, ma_q & {WIDTH{mb_q[k]}}} << (int'(cnt_q) * R + k));
    end
  end

  assign mb_shifted = mb_q >> R;
  assign last_step  = (cnt_q == LAST_CNT) || (EARLY_TERM && (mb_shifted == '0));

  // Next-state and datapath updates; product is only written when a result is final.
  always_comb begin
    state_d   = state_q;
    ma_d      = ma_q;
    mb_d      = mb_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          ma_d    = a;
          mb_d    = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_q + row_sum;
        mb_d  = mb_shifted;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_step) begin
          product_d = acc_q + row_sum;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any in-flight multiply.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ma_q      <= '0;
      mb_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      ma_q      <= ma_d;
      mb_q      <= mb_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == CALC);
  assign product   = product_q;

endmodule

// File: tb/tb_seq_products_mult.sv
// tb_seq_products_mult: directed table vectors on three 8-bit configurations plus
// randomized traffic on two 16-bit configurations against an arithmetic reference.
module tb_seq_products_mult;

  typedef struct {
    int          idx;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
    int          lat;
    string       name;
  } vec_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    int          cyc;
  } rec_t;

  logic        clk;
  logic        rst;

  logic        in_valid8 [3];
  logic        in_ready8 [3];
  logic        out_valid8[3];
  logic        out_ready8[3];
  logic        busy8     [3];
  logic [7:0]  a8        [3];
  logic [7:0]  b8        [3];
  logic [15:0] prod8     [3];

  logic        in_valid16 [2];
  logic        in_ready16 [2];
  logic        out_valid16[2];
  logic        out_ready16[2];
  logic        busy16     [2];
  logic [15:0] a16        [2];
  logic [15:0] b16        [2];
  logic [31:0] prod16     [2];

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  rec_t expq[2][$];
  vec_t vecs[11];

  seq_products_mult #(.WIDTH(8), .R(1), .EARLY_TERM(1'b0)) u_w8_r1 (
    .clk(clk), .rst(rst), .in_valid(in_valid8[0]), .in_ready(in_ready8[0]),
    .a(a8[0]), .b(b8[0]), .out_valid(out_valid8[0]), .out_ready(out_ready8[0]),
    .product(prod8[0]), .busy(busy8[0]));

  seq_products_mult #(.WIDTH(8), .R(2), .EARLY_TERM(1'b0)) u_w8_r2 (
    .clk(clk), .rst(rst), .in_valid(in_valid8[1]), .in_ready(in_ready8[1]),
    .a(a8[1]), .b(b8[1]), .out_valid(out_valid8[1]), .out_ready(out_ready8[1]),
    .product(prod8[1]), .busy(busy8[1]));

  seq_products_mult #(.WIDTH(8), .R(1), .EARLY_TERM(1'b1)) u_w8_et (
    .clk(clk), .rst(rst), .in_valid(in_valid8[2]), .in_ready(in_ready8[2]),
    .a(a8[2]), .b(b8[2]), .out_valid(out_valid8[2]), .out_ready(out_ready8[2]),
    .product(prod8[2]), .busy(busy8[2]));

  seq_products_mult #(.WIDTH(16), .R(4), .EARLY_TERM(1'b0)) u_w16_r4 (
    .clk(clk), .rst(rst), .in_valid(in_valid16[0]), .in_ready(in_ready16[0]),
    .a(a16[0]), .b(b16[0]), .out_valid(out_valid16[0]), .out_ready(out_ready16[0]),
    .product(prod16[0]), .busy(busy16[0]));

  seq_products_mult #(.WIDTH(16), .R(4), .EARLY_TERM(1'b1)) u_w16_r4_et (
    .clk(clk), .rst(rst), .in_valid(in_valid16[1]), .in_ready(in_ready16[1]),
    .a(a16[1]), .b(b16[1]), .out_valid(out_valid16[1]), .out_ready(out_ready16[1]),
    .product(prod16[1]), .busy(busy16[1]));

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to measure accept-to-result latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
  end

  // Hard time limit so a hung handshake still ends the run.
  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference latency: full step count, or the steps needed to consume b's top set bit.
  function automatic int expLat(input int w, input int r, input bit et, input logic [31:0] bv);
    int top;
    top = -1;
    if (!et) return w / r;
    for (int i = 0; i < w; i++) begin
      if (bv[i]) top = i;
    end
    if (top < 0) return 1;
    return (top + r) / r;
  endfunction

  task automatic applyStimulus(input int idx, input logic [7:0] av, input logic [7:0] bv);
    @(negedge clk);
    checkOutput("in_ready_idle", 32'(in_ready8[idx]), 1);
    in_valid8[idx] = 1'b1;
    a8[idx] = av;
    b8[idx] = bv;
    @(posedge clk);
    @(negedge clk);
    in_valid8[idx] = 1'b0;
    a8[idx] = ~av;
    b8[idx] = ~bv;
  endtask

  task automatic waitResult(input int idx, input int exp_lat, input logic [15:0] exp_p,
                            input string name);
    int lat;
    int busy_cycles;
    bit ready_seen;
    lat = 0;
    busy_cycles = 0;
    ready_seen = 1'b0;
    while (!out_valid8[idx] && lat < 64) begin
      if (busy8[idx]) busy_cycles++;
      if (in_ready8[idx]) ready_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
    checkOutput({name, "_lat"}, 32'(lat), 32'(exp_lat));
    checkOutput({name, "_prod"}, 32'(prod8[idx]), 32'(exp_p));
    checkOutput({name, "_busy"}, 32'(busy_cycles), 32'(exp_lat));
    checkOutput({name, "_ready_low"}, 32'(ready_seen | in_ready8[idx]), 0);
  endtask

  task automatic finishOp(input int idx, input logic [15:0] exp_p, input string name);
    out_ready8[idx] = 1'b1;
    @(negedge clk);
    out_ready8[idx] = 1'b0;
    checkOutput({name, "_idle_ready"}, 32'(in_ready8[idx]), 1);
    checkOutput({name, "_valid_drop"}, 32'(out_valid8[idx]), 0);
    checkOutput({name, "_prod_hold"}, 32'(prod8[idx]), 32'(exp_p));
  endtask

  task automatic produce16(input int idx, input int n, output int sent);
    int   tmo;
    rec_t r;
    sent = 0;
    for (int i = 0; i < n; i++) begin
      tmo = 0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      a16[idx] = 16'($urandom);
      b16[idx] = 16'($urandom) >> $urandom_range(0, 16);
      in_valid16[idx] = 1'b1;
      while (!in_ready16[idx] && tmo < 100) begin
        @(negedge clk);
        tmo++;
      end
      if (tmo >= 100) begin
        checkOutput("rand_accept_timeout", 32'(tmo), 0);
        in_valid16[idx] = 1'b0;
        break;
      end
      @(posedge clk);
      @(negedge clk);
      r.a = a16[idx];
      r.b = b16[idx];
      r.cyc = cyc;
      expq[idx].push_back(r);
      in_valid16[idx] = 1'b0;
      sent++;
    end
  endtask

  task automatic consume16(input int idx, input int n, input bit et, output int got);
    int   idle;
    bit   first;
    rec_t r;
    idle = 0;
    first = 1'b1;
    got = 0;
    while (got < n) begin
      @(negedge clk);
      out_ready16[idx] = ($urandom_range(0, 2) != 0);
      if (out_valid16[idx]) begin
        idle = 0;
        if (expq[idx].size() == 0) begin
          checkOutput("rand_spurious_output", 1, 0);
          break;
        end
        r = expq[idx][0];
        if (first) begin
          checkOutput($sformatf("rand%0d_lat", idx), 32'(cyc - r.cyc),
                      32'(expLat(16, 4, et, 32'(r.b))));
          first = 1'b0;
        end
        checkOutput($sformatf("rand%0d_prod", idx), prod16[idx], 32'(r.a) * 32'(r.b));
        if (out_ready16[idx]) begin
          void'(expq[idx].pop_front());
          got++;
          first = 1'b1;
        end
      end else begin
        idle++;
        if (idle > 100) begin
          checkOutput("rand_output_timeout", 32'(idle), 0);
          break;
        end
      end
    end
    @(negedge clk);
    out_ready16[idx] = 1'b0;
  endtask

  // Main sequence: reset values, table vectors, backpressure, mid-op reset, random traffic.
  initial begin
    int sent0, sent1, got0, got1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid8[i] = 1'b0; out_ready8[i] = 1'b0; a8[i] = '0; b8[i] = '0;
    end
    for (int i = 0; i < 2; i++) begin
      in_valid16[i] = 1'b0; out_ready16[i] = 1'b0; a16[i] = '0; b16[i] = '0;
    end

    vecs[0]  = '{0, 8'hFF, 8'hFF, 16'hFE01, 8, "full_scale"};
    vecs[1]  = '{1, 8'hA5, 8'h3C, 16'h26AC, 4, "multi_row"};
    vecs[2]  = '{2, 8'h12, 8'h03, 16'h0036, 2, "early_term"};
    vecs[3]  = '{2, 8'hFF, 8'h00, 16'h0000, 1, "early_zero"};
    vecs[4]  = '{1, 8'h00, 8'hFF, 16'h0000, 4, "r2_zero_a"};
    vecs[5]  = '{2, 8'h80, 8'h80, 16'h4000, 8, "early_msb"};
    vecs[6]  = '{1, 8'hFF, 8'h01, 16'h00FF, 4, "r2_one"};
    vecs[7]  = '{0, 8'h01, 8'h80, 16'h0080, 8, "r1_msb"};
    vecs[8]  = '{2, 8'h07, 8'h05, 16'h0023, 3, "early_mid"};
    vecs[9]  = '{0, 8'hC3, 8'h5A, 16'h448E, 8, "r1_mixed"};
    vecs[10] = '{2, 8'h0B, 8'h10, 16'h00B0, 5, "early_bit4"};

    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("reset%0d_in_ready", i), 32'(in_ready8[i]), 1);
      checkOutput($sformatf("reset%0d_out_valid", i), 32'(out_valid8[i]), 0);
      checkOutput($sformatf("reset%0d_busy", i), 32'(busy8[i]), 0);
      checkOutput($sformatf("reset%0d_product", i), 32'(prod8[i]), 0);
    end
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("reset16_%0d_in_ready", i), 32'(in_ready16[i]), 1);
      checkOutput($sformatf("reset16_%0d_product", i), prod16[i], 0);
    end
    rst = 1'b0;

    for (int v = 0; v < 11; v++) begin
      applyStimulus(vecs[v].idx, vecs[v].a, vecs[v].b);
      waitResult(vecs[v].idx, vecs[v].lat, vecs[v].prod, vecs[v].name);
      finishOp(vecs[v].idx, vecs[v].prod, vecs[v].name);
    end

    applyStimulus(0, 8'h0F, 8'h11);
    waitResult(0, 8, 16'h00FF, "bp");
    for (int c = 0; c < 5; c++) begin
      in_valid8[0] = ~in_valid8[0];
      a8[0] = 8'($urandom);
      b8[0] = 8'($urandom);
      @(negedge clk);
      checkOutput("bp_prod_stable", 32'(prod8[0]), 32'h00FF);
      checkOutput("bp_out_valid", 32'(out_valid8[0]), 1);
      checkOutput("bp_in_ready", 32'(in_ready8[0]), 0);
    end
    in_valid8[0] = 1'b0;
    finishOp(0, 16'h00FF, "bp");
    @(negedge clk);
    checkOutput("bp_no_capture", 32'(busy8[0]), 0);

    applyStimulus(0, 8'hFF, 8'hFF);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("rst_out_valid", 32'(out_valid8[0]), 0);
    checkOutput("rst_busy", 32'(busy8[0]), 0);
    checkOutput("rst_product", 32'(prod8[0]), 0);
    checkOutput("rst_in_ready", 32'(in_ready8[0]), 1);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 8'h02, 8'h03);
    waitResult(0, 8, 16'h0006, "after_rst");
    finishOp(0, 16'h0006, "after_rst");

    fork
      produce16(0, 500, sent0);
      consume16(0, 500, 1'b0, got0);
      produce16(1, 500, sent1);
      consume16(1, 500, 1'b1, got1);
    join
    checkOutput("rand0_sent", 32'(sent0), 500);
    checkOutput("rand0_in_vs_out", 32'(got0), 32'(sent0));
    checkOutput("rand0_leftover", 32'(expq[0].size()), 0);
    checkOutput("rand1_sent", 32'(sent1), 500);
    checkOutput("rand1_in_vs_out", 32'(got1), 32'(sent1));
    checkOutput("rand1_leftover", 32'(expq[1].size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_products_mult.md
Name: seq_products_mult

Overview:
Parametrised iterative unsigned multiplier for the FPU mantissa datapath, built from AND-row partial products. Each cycle it generates R partial-product rows (multiplicand ANDed with one multiplier bit) and accumulates them into a double-width product. Inputs and outputs use valid/ready handshakes, and optional early termination is available. It sits between the operand-unpack stage and the normaliser.

Parameters:
WIDTH, 8, operand width in bits; must be at least 2.
R, 1, partial-product rows per cycle; must divide WIDTH exactly, otherwise elaboration fails.
EARLY_TERM, 0, when 1, finish as soon as all remaining multiplier bits are zero.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous reset, active-high.
in_valid  input  1  operands a/b valid.
in_ready  output  1  block can accept operands; high only in IDLE.
a  input  WIDTH  multiplicand, unsigned.
b  input  WIDTH  multiplier, unsigned.
out_valid  output  1  product valid; high only in DONE.
out_ready  input  1  downstream accepts product.
product  output  2*WIDTH  a*b; registered.
busy  output  1  high in CALC.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, step counter=0, internal operand registers=0.
- States are IDLE, CALC and DONE.
- IDLE:
  - Accept occurs on in_valid&&in_ready at a rising edge.
  - On accept: latch a into the multiplicand register and b into the multiplier shift register, clear the accumulator and counter, then go to CALC.
  - in_valid while not in IDLE is ignored; a and b are sampled only at accept.
- CALC, one step per cycle:
  - acc += sum over k=0..R-1 of ({WIDTH{mb[k]}} & ma) << (cnt*R + k).
  - mb >>= R; cnt += 1.
  - The accumulator is 2*WIDTH bits and can never overflow.
- CALC exit:
  - If cnt reaches WIDTH/R-1 at a step edge, that step's edge moves to DONE.
  - If EARLY_TERM=1 and mb after the shift is all zero, that step's edge moves to DONE.
  - At least one step always executes.
- Latency: accept at edge t0 → out_valid high after edge t0+WIDTH/R (EARLY_TERM=0). With EARLY_TERM=1, latency is ceil((index of b's MSB set + 1)/R) edges, minimum 1.
- DONE:
  - product holds the final acc and stays stable while out_valid=1 && out_ready=0, for unbounded backpressure.
  - out_valid&&out_ready at an edge → IDLE. product keeps its last value until the next DONE.
- No accept in the same cycle as output handshake. Minimum throughput is one operation per WIDTH/R+2 cycles.
- product updates only when entering DONE; the intermediate accumulator is not visible on product.
- Async reset in any state aborts immediately: the next cycle after deassertion is IDLE with in_ready=1 and out_valid=0. A partially computed result is discarded.
- out_ready in IDLE or CALC is ignored.

Test Plan:
- Full-scale: WIDTH=8, R=1, a=0xFF, b=0xFF, in_valid for one cycle → out_valid exactly 8 edges after accept, product=0xFE01; busy high for 8 cycles; in_ready low from accept until after the output handshake.
- Multi-row: WIDTH=8, R=2, a=0xA5, b=0x3C → out_valid 4 edges after accept, product=0x26AC.
- Early termination: EARLY_TERM=1, R=1, a=0x12, b=0x03 → out_valid 2 edges after accept, product=0x0036. Also a=0xFF, b=0x00 → out_valid 1 edge after accept, product=0x0000.
- Backpressure: after 0x0F*0x11 completes, hold out_ready=0 for 5 cycles while toggling in_valid with new operands → product stays 0x00FF, out_valid stays 1, in_ready stays 0, no operand captured. Then out_ready=1 → IDLE next edge, in_ready=1.
- Reset mid-operation: accept 0xFF*0xFF, assert rst asynchronously during the 3rd CALC cycle (between edges) → out_valid=0, busy=0, product=0, in_ready=1 immediately. After release, 0x02*0x03 → product=0x0006 with normal latency.
- Randomised back-to-back: 1000 random a/b pairs with WIDTH=16, R=4, both EARLY_TERM settings, random out_ready → every product equals a*b and the operation count in equals the count out.
